exe_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EXE stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded register operands and funct3 of an M-extension instruction, and produces a 32-bit result for the EXE/MEM register. While the operation runs it raises a combinational stall request that freezes the ID/EX register and all earlier stages. Multiplies complete in 2 cycles. Divides and remainders complete in 33 cycles, or 1 cycle for the special cases.

---
 rtl/exe_muldiv.sv | 159 +++++++++++++++
 tb/tb_exe_muldiv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit for the EXE stage.
// Multiplies take 2 cycles. Divides and remainders take 33 cycles, or 1 cycle
// for divide-by-zero and signed overflow.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   i_start             valid M-extension op in EXE this cycle
//   i_funct3            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_rs1_data          operand A (forwarded)
//   i_rs2_data          operand B (forwarded)
//   i_flush             kill the in-flight op
//   o_busy              combinational stall request to upstream registers
//   o_done              one-cycle pulse, o_result valid for writeback
//   o_result            result, held until the next result write
module exe_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_op;        // funct3[1:0]; funct3[2] is implied by the state
  logic [31:0] r_a;         // MUL: operand A; DIV: dividend magnitude, shifts into quotient
  logic [31:0] r_b;         // MUL: operand B; DIV: divisor magnitude
  logic [31:0] r_rem;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_result;
  logic        r_done;

  // Issue-side decode
  logic        w_accept, w_signed, w_div0, w_ovf, w_special, w_a_neg, w_b_neg;
  logic [31:0] w_special_res, w_mag_a, w_mag_b;

  always_comb begin
    w_accept      = (r_state == StIdle) && i_start && !i_flush;
    w_signed      = ~i_funct3[0];  // DIV and REM
    w_div0        = (i_rs2_data == 32'd0);
    w_ovf         = w_signed && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
    w_special     = w_div0 || w_ovf;
    w_a_neg       = w_signed && i_rs1_data[31];
    w_b_neg       = w_signed && i_rs2_data[31];
    w_mag_a       = w_a_neg ? -i_rs1_data : i_rs1_data;
    w_mag_b       = w_b_neg ? -i_rs2_data : i_rs2_data;
    if (w_div0) begin
      w_special_res = i_funct3[1] ? i_rs1_data : 32'hFFFF_FFFF;
    end else begin
      w_special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Multiply: 64 bits of the product of sign/zero-extended operands is enough
  logic        w_sa, w_sb;
  logic [63:0] w_op_a, w_op_b, w_prod;
  logic [31:0] w_mul_res;

  always_comb begin
    w_sa      = ((r_op == 2'b01) || (r_op == 2'b10)) && r_a[31];
    w_sb      = (r_op == 2'b01) && r_b[31];
    w_op_a    = {{32{w_sa}}, r_a};
    w_op_b    = {{32{w_sb}}, r_b};
    w_prod    = w_op_a * w_op_b;
    w_mul_res = (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];
  end

  // Restoring divide step. The partial remainder is always below the divisor,
  // so bit 32 of the difference is a clean borrow flag.
  logic [32:0] w_shift, w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_nxt, w_quo_nxt, w_div_res;

  always_comb begin
    w_shift   = {r_rem, r_a[31]};
    w_diff    = w_shift - {1'b0, r_b};
    w_qbit    = ~w_diff[32];
    w_rem_nxt = w_qbit ? w_diff[31:0] : w_shift[31:0];
    w_quo_nxt = {r_a[30:0], w_qbit};
    if (r_op[1]) begin
      w_div_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end else begin
      w_div_res = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!i_funct3[2])   w_state_d = StMul;
          else if (w_special) w_state_d = StDone;
          else                w_state_d = StDiv;
        end
      end
      StMul:  w_state_d = StDone;
      StDiv:  if (r_cnt == 5'd0) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (i_flush) w_state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_op     <= 2'b00;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rem    <= 32'd0;
      r_cnt    <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= (w_state_d == StDone);
      if (w_accept) begin
        r_op    <= i_funct3[1:0];
        r_neg_q <= ~i_funct3[1] && (w_a_neg ^ w_b_neg);
        r_neg_r <= i_funct3[1] && w_a_neg;
        r_rem   <= 32'd0;
        r_cnt   <= 5'd31;
        if (i_funct3[2]) begin
          r_a <= w_mag_a;
          r_b <= w_mag_b;
          if (w_special) r_result <= w_special_res;
        end else begin
          r_a <= i_rs1_data;
          r_b <= i_rs2_data;
        end
      end else if (!i_flush) begin
        if (r_state == StMul) r_result <= w_mul_res;
        if (r_state == StDiv) begin
          r_a   <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_result <= w_div_res;
        end
      end
    end
  end

  // Stall must act in the issue cycle, hence combinational
  assign o_busy   = !rst && (w_accept || (r_state == StMul) || (r_state == StDiv));
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed vector table, flush/reset
// sequences, and randomized ops against a plain-arithmetic reference model.
module tb_exe_muldiv;

  logic        clk, rst, i_start, i_flush, o_busy, o_done;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data, i_rs2_data, o_result;

  int n_pass = 0;
  int n_total = 0;

  exe_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op and waits for done. Operands are scrambled after the issue
  // cycle so a design that fails to latch them gets caught.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit wait_edge, output logic [31:0] res, output int lat,
                        output int nbusy);
    if (wait_edge) @(negedge clk);
    i_start = 1'b1; i_funct3 = f3; i_rs1_data = a; i_rs2_data = b;
    #1;
    check("done_at_issue", {31'd0, o_done}, 32'd0);
    lat = 99; nbusy = 0; res = 'x;
    for (int c = 0; c < 40; c++) begin
      if (o_done) begin
        lat = c; res = o_result;
        break;
      end
      if (o_busy) nbusy++;
      @(negedge clk);
      i_start = 1'b0;
      i_funct3 = 3'($urandom); i_rs1_data = $urandom; i_rs2_data = $urandom;
      #1;
    end
    i_start = 1'b0;
  endtask

  task automatic do_check_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                             input bit wait_edge);
    logic [31:0] res;
    int          lat, nbusy;
    run_op(f3, a, b, wait_edge, res, lat, nbusy);
    check($sformatf("%s result f3=%0d a=%h b=%h", tag, f3, a, b), res, exp);
    check($sformatf("%s latency f3=%0d", tag, f3), 32'(lat), 32'(exp_lat));
    check($sformatf("%s busy_cycles f3=%0d", tag, f3), 32'(nbusy), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{3'b011, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 2};
    vecs[2]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'b101, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b110, 32'h1234_5678,  32'd0,         32'h1234_5678, 1};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'b100, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 33};
    vecs[13] = '{3'b110, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 33};

    // Reset state, with start high to show busy stays low under reset
    rst = 1'b1; i_start = 1'b1; i_flush = 1'b0; i_funct3 = 3'b000;
    i_rs1_data = 32'd3; i_rs2_data = 32'd4;
    #1;
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset done", {31'd0, o_done}, 32'd0);
    check("reset result", o_result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; i_start = 1'b0;

    foreach (vecs[i])
      do_check_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                  vecs[i].lat, 1'b1);

    // start with flush in IDLE: not accepted
    @(negedge clk);
    i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'b100; i_rs1_data = 32'd9; i_rs2_data = 32'd2;
    #1;
    check("flush+start busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    #1;
    check("flush+start no accept busy", {31'd0, o_busy}, 32'd0);
    check("flush+start no done", {31'd0, o_done}, 32'd0);

    // Flush in cycle 10 of a DIV
    prev = o_result;
    @(negedge clk);
    i_start = 1'b1; i_funct3 = 3'b100; i_rs1_data = 32'd1000; i_rs2_data = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    i_flush = 1'b1;
    #1;
    check("flush cycle busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    check("after flush busy", {31'd0, o_busy}, 32'd0);
    check("after flush done", {31'd0, o_done}, 32'd0);
    check("after flush result", o_result, prev);
    do_check_op("mul after flush", 3'b000, 32'd12345, 32'd678, 32'd8369910, 2, 1'b0);

    // Reset pulse in cycle 5 of a DIV, start held high through it
    @(negedge clk);
    i_start = 1'b1; i_funct3 = 3'b101; i_rs1_data = 32'd5000; i_rs2_data = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    rst = 1'b1; i_start = 1'b1; i_funct3 = 3'b011;
    #1;
    check("rst mid busy", {31'd0, o_busy}, 32'd0);
    check("rst mid done", {31'd0, o_done}, 32'd0);
    check("rst mid result", o_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_check_op("mul after rst", 3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 2, 1'b0);

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin b = $urandom; a = 32'($urandom_range(0, 3)); end
        default: b = $urandom;
      endcase
      do_check_op($sformatf("rand%0d", n), f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
